// File: rtl/acc_result_streamer_pkg.sv
// Shared types for the accumulator result path.
// Result array layout and stream FSM states.
package acc_result_streamer_pkg;

  localparam int PRECISION_D    = 8;
  localparam int NUM_FEATURES_D = 1;
  localparam int M_D            = 6;

  typedef logic [PRECISION_D-1:0]
    result_arr_t [NUM_FEATURES_D][M_D];

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } strm_state_t;

endpackage

// File: rtl/acc_result_streamer_frame_slot_buffer.sv
// Two-slot result frame storage: whole-frame write
// on wr_en, combinational element read by (slot, f, b).
module frame_slot_buffer
  import acc_result_streamer_pkg::*;
#(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 1,
  parameter int M            = 6,
  parameter int FIW          = 1,
  parameter int BIW          = 3
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic                 wr_ptr,
  input  logic [PRECISION-1:0] wr_data [NUM_FEATURES][M],
  input  logic                 rd_ptr,
  input  logic [FIW-1:0]       rd_f,
  input  logic [BIW-1:0]       rd_b,
  output logic [PRECISION-1:0] rd_data
);

  logic [PRECISION-1:0] mem [2][NUM_FEATURES][M];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_ptr][rd_f][rd_b];

endmodule

// File: rtl/acc_result_streamer.sv
// Snapshots accumulator results into a double buffer
// and streams them one element per valid/ready beat.
module acc_result_streamer
  import acc_result_streamer_pkg::*;
#(
  parameter int PRECISION    = 8,
  parameter int NUM_FEATURES = 1,
  parameter int M            = 6,
  parameter int FRAMES       = 2,
  localparam int FW = $clog2(NUM_FEATURES) + 1,
  localparam int BW = $clog2(M) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PRECISION-1:0] acc_in [NUM_FEATURES][M],
  input  logic                 acc_done,
  output logic                 acc_clr,
  output logic [PRECISION-1:0] m_data,
  output logic [FW-1:0]        m_feature,
  output logic [BW-1:0]        m_bucket,
  output logic                 m_last,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 overrun,
  input  logic                 overrun_clr
);

  localparam int FIW =
    (NUM_FEATURES > 1) ? $clog2(NUM_FEATURES) : 1;
  localparam int BIW = (M > 1) ? $clog2(M) : 1;
  localparam logic [FIW-1:0] F_LAST =
    FIW'(NUM_FEATURES - 1);
  localparam logic [BIW-1:0] B_LAST = BIW'(M - 1);
  localparam logic [1:0] OCC_FULL = 2'(FRAMES);

  strm_state_t          state_q, state_d;
  logic [1:0]           occ_q, occ_d;
  logic                 wp_q, rp_q;
  logic [FIW-1:0]       f_q;
  logic [BIW-1:0]       b_q;
  logic                 acc_clr_q, overrun_q;
  logic                 last_elem, beat, fin;
  logic                 room, cap, drop;
  logic [PRECISION-1:0] rd_data;

  frame_slot_buffer #(
    .PRECISION    (PRECISION),
    .NUM_FEATURES (NUM_FEATURES),
    .M            (M),
    .FIW          (FIW),
    .BIW          (BIW)
  ) u_buf (
    .clk     (clk),
    .wr_en   (cap),
    .wr_ptr  (wp_q),
    .wr_data (acc_in),
    .rd_ptr  (rp_q),
    .rd_f    (f_q),
    .rd_b    (b_q),
    .rd_data (rd_data)
  );

  assign last_elem = (f_q == F_LAST) && (b_q == B_LAST);
  assign beat      = m_valid & m_ready;
  assign fin       = beat & last_elem;
  // A full buffer still has room when the frame being
  // read retires this cycle; the write lands in that
  // slot at the same edge the read moves on.
  assign room      = (occ_q != OCC_FULL) | fin;
  assign cap       = acc_done & room;
  assign drop      = acc_done & ~room;
  assign occ_d     = occ_q + {1'b0, cap} - {1'b0, fin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (occ_d != 2'd0) state_d = STREAM;
      end
      STREAM: begin
        if (fin) begin
          state_d = (occ_d != 2'd0) ? STREAM : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid   = (state_q == STREAM);
    m_data    = m_valid ? rd_data : '0;
    m_feature = m_valid ? FW'(f_q) : '0;
    m_bucket  = m_valid ? BW'(b_q) : '0;
    m_last    = m_valid & last_elem;
    acc_clr   = acc_clr_q;
    overrun   = overrun_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q     <= 2'd0;
      wp_q      <= 1'b0;
      rp_q      <= 1'b0;
      f_q       <= '0;
      b_q       <= '0;
      acc_clr_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      occ_q     <= occ_d;
      acc_clr_q <= cap;
      if (cap) wp_q <= ~wp_q;
      if (fin) rp_q <= ~rp_q;
      if (beat) begin
        if (last_elem) begin
          f_q <= '0;
          b_q <= '0;
        end else if (b_q == B_LAST) begin
          f_q <= f_q + 1'b1;
          b_q <= '0;
        end else begin
          b_q <= b_q + 1'b1;
        end
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

endmodule
